// File: rtl/serial_loader_pkg.sv
// Shared types and constants for the serial word loader.
package serial_loader_pkg;

    // Receiver frame states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } loader_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // A frame is accepted only if its stop bit is correct and no parity error was seen.
    function automatic logic stop_ok(input logic stop_bit, input logic par_err);
        return (stop_bit == STOP_BIT) && !par_err;
    endfunction

endpackage

// File: rtl/serial_word_loader_sipo_shift.sv
// N-bit serial-in/parallel-out register. Bits enter at the MSB and move
// toward the LSB, so an LSB-first stream lands in natural bit order.
module sipo_shift #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [N-1:0] q
);

    generate
        if (N == 1) begin : g_single
            // Single-bit case: the shift degenerates to a load
            always_ff @(posedge clk) begin
                if (rst || clr)
                    q <= '0;
                else if (shift_en)
                    q <= bit_in;
            end
        end else begin : g_multi
            // Right shift with the new bit entering at the MSB
            always_ff @(posedge clk) begin
                if (rst || clr)
                    q <= '0;
                else if (shift_en)
                    q <= {bit_in, q[N-1:1]};
            end
        end
    endgenerate

endmodule

// File: rtl/serial_word_loader.sv
// Framed serial receiver that assembles an N-bit word and issues a
// single-cycle load pulse for a downstream enable register. Frames with a
// bad parity or stop bit raise frame_err instead and never update word_out.
module serial_word_loader
    import serial_loader_pkg::*;
#(
    parameter int N         = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [N-1:0] word_out,
    output logic         load_en,
    output logic         busy,
    output logic         frame_err
);

    localparam int             CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             par_acc_q;
    logic             par_err_q;
    logic [N-1:0]     shift_q;

    logic start_frame;
    logic shift_en;
    logic parity_strobe;
    logic stop_strobe;
    logic frame_good;

    // State register; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state decode; every transition is gated by bit_valid so gaps freeze the frame
    always_comb begin
        state_d       = state_q;
        start_frame   = 1'b0;
        shift_en      = 1'b0;
        parity_strobe = 1'b0;
        stop_strobe   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bit_valid && (bit_in == START_BIT)) begin
                    start_frame = 1'b1;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_IDX)
                        state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    parity_strobe = 1'b1;
                    state_d       = STOP;
                end
            end
            STOP: begin
                if (bit_valid) begin
                    stop_strobe = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame_good = stop_ok(bit_in, par_err_q);
    assign busy       = (state_q != IDLE);

    // Bit counter, running data parity and the latched parity-error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
        end else if (start_frame) begin
            cnt_q     <= '0;
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
        end else if (shift_en) begin
            cnt_q     <= cnt_q + CNT_W'(1);
            par_acc_q <= par_acc_q ^ bit_in;
        end else if (parity_strobe) begin
            par_err_q <= (bit_in != par_acc_q);
        end
    end

    sipo_shift #(
        .N(N)
    ) u_sipo (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_frame),
        .shift_en (shift_en),
        .bit_in   (bit_in),
        .q        (shift_q)
    );

    // Registered result: load pulse and word on a good frame, error pulse otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            word_out  <= '0;
            load_en   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            load_en   <= stop_strobe && frame_good;
            frame_err <= stop_strobe && !frame_good;
            if (stop_strobe && frame_good)
                word_out <= shift_q;
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Self-checking bench for serial_word_loader: directed frames followed by
// randomized frames with random errors, gaps and idle bits.
module tb_serial_word_loader;

    localparam int N  = 4;
    localparam bit PE = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_valid;
    logic [N-1:0] word_out;
    logic         load_en;
    logic         busy;
    logic         frame_err;

    logic [N-1:0] reg_q;
    logic [N-1:0] exp_word;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    serial_word_loader #(
        .N         (N),
        .PARITY_EN (PE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .word_out  (word_out),
        .load_en   (load_en),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Downstream enable register fed by word_out/load_en
    always @(posedge clk) begin
        if (rst)
            reg_q <= '0;
        else if (load_en)
            reg_q <= word_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the given inputs, then check the steady (no-pulse) outputs
    task automatic step(input logic v, input logic b, input logic exp_busy);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
        chk("busy",      32'(busy),      32'(exp_busy));
        chk("load_idle", 32'(load_en),   0);
        chk("ferr_idle", 32'(frame_err), 0);
        chk("word_hold", 32'(word_out),  32'(exp_word));
        chk("reg_q",     32'(reg_q),     32'(exp_word));
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        bit_valid = 1'($urandom);
        bit_in    = 1'($urandom);
        exp_word  = '0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            chk("rst_busy", 32'(busy),      0);
            chk("rst_load", 32'(load_en),   0);
            chk("rst_ferr", 32'(frame_err), 0);
            chk("rst_word", 32'(word_out),  0);
        end
        rst = 1'b0;
    endtask

    // Send a whole frame; gaps of glo..ghi invalid cycles precede every bit after the start bit
    task automatic send_frame(input logic [N-1:0] w, input bit par_bad, input bit stop_v,
                              input int glo, input int ghi);
        bit q[$];
        bit ok;
        q.push_back(1'b0);
        for (int i = 0; i < N; i++)
            q.push_back(w[i]);
        if (PE)
            q.push_back((^w) ^ par_bad);
        q.push_back(stop_v);
        ok = stop_v && !(PE && par_bad);
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0)
                repeat ($urandom_range(ghi, glo)) step(1'b0, 1'($urandom), 1'b1);
            if (k < q.size() - 1) begin
                step(1'b1, q[k], 1'b1);
            end else begin
                bit_valid = 1'b1;
                bit_in    = q[k];
                @(posedge clk);
                #1;
                if (ok)
                    exp_word = w;
                chk("load_pulse", 32'(load_en),   32'(ok));
                chk("ferr_pulse", 32'(frame_err), 32'(!ok));
                chk("word_upd",   32'(word_out),  32'(exp_word));
                chk("busy_end",   32'(busy),      0);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        exp_word  = '0;

        do_reset(2);
        repeat (5) step(1'b1, 1'b1, 1'b0);

        // Good frame 0xA
        send_frame(4'hA, 1'b0, 1'b1, 0, 0);
        step(1'b1, 1'b1, 1'b0);

        // Parity error on 0x3
        send_frame(4'h3, 1'b1, 1'b1, 0, 0);
        step(1'b1, 1'b1, 1'b0);

        // Stop error on 0x6 with 3-cycle gaps
        send_frame(4'h6, 1'b0, 1'b0, 3, 3);
        step(1'b1, 1'b1, 1'b0);

        // Abort mid-frame with reset, then a good 0x5
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        do_reset(1);
        send_frame(4'h5, 1'b0, 1'b1, 0, 0);
        step(1'b1, 1'b1, 1'b0);

        // Back-to-back 0xC then 0x9
        send_frame(4'hC, 1'b0, 1'b1, 0, 0);
        send_frame(4'h9, 1'b0, 1'b1, 0, 0);
        step(1'b1, 1'b1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 300; f++) begin
            int idle_n;
            idle_n = int'($urandom_range(3, 0));
            for (int i = 0; i < idle_n; i++) begin
                if ($urandom_range(1, 0) == 0)
                    step(1'b1, 1'b1, 1'b0);
                else
                    step(1'b0, 1'($urandom), 1'b0);
            end
            send_frame(N'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) != 0),
                       0, int'($urandom_range(2, 0)));
        end
        step(1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
